// File: rtl/axi_burst_master.sv
// axi_burst_master: AXI4 initiator that turns one command into one INCR burst,
// read or write, with a single status word returned per command.
// Optional build macro: AXI_BURST_MASTER_4K_CHECK_EN. When it is defined, commands
// whose burst would cross a 4 KB boundary complete with SLVERR and are not issued.
module axi_burst_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    // command / status
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  cmd_write,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] s_wr_data,
    input  logic [STRB_WIDTH-1:0] s_wr_strb,
    input  logic                  s_wr_valid,
    output logic                  s_wr_ready,
    output logic [DATA_WIDTH-1:0] m_rd_data,
    output logic                  m_rd_last,
    output logic                  m_rd_valid,
    input  logic                  m_rd_ready,
    output logic [1:0]            sts_resp,
    output logic                  sts_valid,
    input  logic                  sts_ready,
    // AXI4 write address
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    // AXI4 write data
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    // AXI4 write response
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // AXI4 read address
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // AXI4 read data
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int                    SIZE      = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, STATUS
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            resp_q, resp_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic [ADDR_WIDTH-1:0] cmd_addr_aligned;
    assign cmd_addr_aligned = cmd_addr & ADDR_MASK;

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    // Offset of the last byte of the burst from the start of its 4 KB page.
    logic [31:0] burst_end;
    logic        cross_4k;
    assign burst_end = 32'(cmd_addr_aligned[11:0])
                     + ((32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH)) - 32'd1;
    assign cross_4k  = (burst_end > 32'd4095);
`endif

    // IDs are not used: one transaction is outstanding at a time.
    logic unused_ids;
    assign unused_ids = ^{m_axi_bid, m_axi_rid};

    // Constant address-channel fields; address and length come from the latched command.
    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;

    // Data buses pass straight through; their valids are gated by state below.
    assign m_axi_wdata = s_wr_data;
    assign m_axi_wstrb = s_wr_strb;
    assign m_rd_data   = m_axi_rdata;
    assign m_rd_last   = m_axi_rlast;
    assign cmd_ready   = cmd_ready_q;
    assign sts_resp    = resp_q;

    // State and command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            resp_q      <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Next-state and handshake logic for the shared read/write sequencer.
    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no latches.
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        resp_d        = resp_q;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wlast   = 1'b0;
        s_wr_ready    = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_rd_valid    = 1'b0;
        sts_valid     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr_aligned;
                    len_d  = cmd_len;
                    resp_d = 2'b00;
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
                    if (cross_4k) begin
                        resp_d  = 2'b10;
                        state_d = STATUS;
                    end else
`endif
                    if (cmd_write) state_d = WR_ADDR;
                    else           state_d = RD_ADDR;
                end
            end
            WR_ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    cnt_d   = len_q;
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                m_axi_wvalid = s_wr_valid;
                s_wr_ready   = m_axi_wready;
                m_axi_wlast  = (cnt_q == 8'd0);
                if (s_wr_valid && m_axi_wready) begin
                    if (cnt_q == 8'd0) state_d = WR_RESP;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    resp_d  = m_axi_bresp;
                    state_d = STATUS;
                end
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                m_rd_valid   = m_axi_rvalid;
                m_axi_rready = m_rd_ready;
                if (m_axi_rvalid && m_rd_ready) begin
                    if (m_axi_rresp > resp_q) resp_d = m_axi_rresp;
                    if (m_axi_rlast) state_d = STATUS;
                end
            end
            STATUS: begin
                sts_valid = 1'b1;
                if (sts_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed testbench for axi_burst_master with a small reactive AXI4 memory slave.
module tb_axi_burst_master;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // DUT-facing signals
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_len = '0;
    logic          cmd_write = 1'b0, cmd_valid = 1'b0, cmd_ready;
    logic [DW-1:0] s_wr_data = '0;
    logic [SW-1:0] s_wr_strb = '0;
    logic          s_wr_valid = 1'b0, s_wr_ready;
    logic [DW-1:0] m_rd_data;
    logic          m_rd_last, m_rd_valid, m_rd_ready = 1'b1;
    logic [1:0]    sts_resp;
    logic          sts_valid, sts_ready = 1'b1;
    logic [IW-1:0] m_axi_awid, m_axi_arid;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]    m_axi_awburst, m_axi_arburst;
    logic          m_axi_awlock, m_axi_arlock;
    logic [3:0]    m_axi_awcache, m_axi_arcache;
    logic          m_axi_awvalid, m_axi_arvalid;
    logic          m_axi_awready = 1'b1, m_axi_wready = 1'b1, m_axi_arready = 1'b1;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [SW-1:0] m_axi_wstrb;
    logic          m_axi_wlast, m_axi_wvalid;
    logic [IW-1:0] m_axi_bid = '0, m_axi_rid = '0;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_write(cmd_write),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_wr_data(s_wr_data), .s_wr_strb(s_wr_strb), .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
        .m_rd_data(m_rd_data), .m_rd_last(m_rd_last), .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready),
        .sts_resp(sts_resp), .sts_valid(sts_valid), .sts_ready(sts_ready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    // ---------------- slave model configuration ----------------
    logic       stall_en = 1'b0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [1:0] rerr_resp = 2'b00;
    int         rerr_beat = -1;

    logic [31:0] mem [0:1023];
    logic [9:0]  wr_ptr, rd_ptr;
    logic [8:0]  rd_left;
    int          r_beat, w_idx, cur_awlen;
    logic        bvalid_q;
    logic        r_en = 1'b1;

    assign m_axi_bvalid = bvalid_q;
    assign m_axi_bresp  = bresp_cfg;
    assign m_axi_rvalid = (rd_left != 9'd0) && r_en;
    assign m_axi_rdata  = mem[rd_ptr];
    assign m_axi_rlast  = (rd_left == 9'd1);
    assign m_axi_rresp  = (r_beat == rerr_beat) ? rerr_resp : 2'b00;

    // Ready/backpressure generator: all stall sources change on the falling edge.
    initial forever begin
        @(negedge clk);
        if (stall_en) begin
            m_axi_awready = 1'($urandom_range(0, 1));
            m_axi_wready  = 1'($urandom_range(0, 1));
            m_axi_arready = 1'($urandom_range(0, 1));
            r_en          = 1'($urandom_range(0, 1));
            m_rd_ready    = 1'($urandom_range(0, 1));
            sts_ready     = 1'($urandom_range(0, 1));
        end else begin
            m_axi_awready = 1'b1;
            m_axi_wready  = 1'b1;
            m_axi_arready = 1'b1;
            r_en          = 1'b1;
            m_rd_ready    = 1'b1;
            sts_ready     = 1'b1;
        end
    end

    // Memory slave: accepts bursts into mem and returns read bursts from it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bvalid_q <= 1'b0; rd_left <= '0; wr_ptr <= '0; rd_ptr <= '0;
            r_beat <= 0; w_idx <= 0; cur_awlen <= 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                wr_ptr <= m_axi_awaddr[11:2]; w_idx <= 0; cur_awlen <= int'(m_axi_awlen);
            end
            if (m_axi_wvalid && m_axi_wready) begin
                for (int b = 0; b < SW; b++)
                    if (m_axi_wstrb[b]) mem[wr_ptr][8*b +: 8] <= m_axi_wdata[8*b +: 8];
                wr_ptr <= wr_ptr + 10'd1;
                w_idx  <= w_idx + 1;
                if (m_axi_wlast) bvalid_q <= 1'b1;
            end
            if (m_axi_bvalid && m_axi_bready) bvalid_q <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                rd_ptr <= m_axi_araddr[11:2]; rd_left <= 9'(m_axi_arlen) + 9'd1; r_beat <= 0;
            end else if (m_axi_rvalid && m_axi_rready) begin
                rd_ptr <= rd_ptr + 10'd1; rd_left <= rd_left - 9'd1; r_beat <= r_beat + 1;
            end
        end
    end

    // ---------------- monitors ----------------
    int          aw_hs = 0, ar_hs = 0, w_beats = 0, w_last_err = 0, w_early = 0, stab_err = 0;
    logic [15:0] last_awaddr = '0, last_araddr = '0;
    logic [7:0]  last_awlen = '0, last_arlen = '0;
    logic [31:0] rd_q [$];
    logic        rd_last_q [$];
    logic [1:0]  sts_q [$];
    logic        aw_hold = 1'b0, ar_hold = 1'b0, aw_open;
    logic [15:0] aw_hold_addr = '0, ar_hold_addr = '0;
    logic [7:0]  aw_hold_len = '0, ar_hold_len = '0;

    // A W beat is legal only after the AW handshake of the current burst.
    always @(posedge clk or posedge rst) begin
        if (rst) aw_open <= 1'b0;
        else if (m_axi_awvalid && m_axi_awready) aw_open <= 1'b1;
        else if (m_axi_wvalid && m_axi_wready && m_axi_wlast) aw_open <= 1'b0;
    end

    // Channel observers: handshake counters, wlast placement, address stability.
    always @(posedge clk) begin
        if (m_axi_awvalid && m_axi_awready) begin
            aw_hs <= aw_hs + 1; last_awaddr <= m_axi_awaddr; last_awlen <= m_axi_awlen;
        end
        if (m_axi_arvalid && m_axi_arready) begin
            ar_hs <= ar_hs + 1; last_araddr <= m_axi_araddr; last_arlen <= m_axi_arlen;
        end
        if (m_axi_wvalid && m_axi_wready) begin
            w_beats <= w_beats + 1;
            if (m_axi_wlast !== (w_idx == cur_awlen)) w_last_err <= w_last_err + 1;
        end
        if (m_axi_wvalid && !aw_open) w_early <= w_early + 1;
        aw_hold      <= m_axi_awvalid && !m_axi_awready;
        aw_hold_addr <= m_axi_awaddr;
        aw_hold_len  <= m_axi_awlen;
        ar_hold      <= m_axi_arvalid && !m_axi_arready;
        ar_hold_addr <= m_axi_araddr;
        ar_hold_len  <= m_axi_arlen;
        if ((aw_hold && (!m_axi_awvalid || m_axi_awaddr != aw_hold_addr || m_axi_awlen != aw_hold_len)) ||
            (ar_hold && (!m_axi_arvalid || m_axi_araddr != ar_hold_addr || m_axi_arlen != ar_hold_len)))
            stab_err <= stab_err + 1;
        if (m_rd_valid && m_rd_ready) begin
            rd_q.push_back(m_rd_data); rd_last_q.push_back(m_rd_last);
        end
        if (sts_valid && sts_ready) sts_q.push_back(sts_resp);
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue_cmd(input logic [15:0] a, input logic [7:0] l, input logic w);
        int n;
        n = 0;
        @(negedge clk);
        cmd_addr = a; cmd_len = l; cmd_write = w; cmd_valid = 1'b1;
        #4;
        while (!cmd_ready && n < 200) begin @(negedge clk); #4; n++; end
        checks++;
        if (!cmd_ready) begin
            errors++; $display("FAIL cmd_accept: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_wr(input int n, input logic [31:0] first, input logic [31:0] step,
                           input logic [3:0] strb);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            @(negedge clk);
            if (stall_en && $urandom_range(0, 3) == 0) begin s_wr_valid = 1'b0; @(negedge clk); end
            s_wr_valid = 1'b1; s_wr_data = first + step * i; s_wr_strb = strb;
            #4;
            while (!s_wr_ready && w < 300) begin @(negedge clk); #4; w++; end
            if (!s_wr_ready) begin
                checks++; errors++;
                $display("FAIL wr_beat_timeout: beat %0d s_wr_ready=%b, required 1", i, s_wr_ready);
                break;
            end
        end
        @(negedge clk);
        s_wr_valid = 1'b0;
    endtask

    task automatic wait_sts(input int base, output logic [1:0] resp);
        int n;
        n = 0;
        while (sts_q.size() <= base && n < 4000) begin @(negedge clk); n++; end
        checks++;
        if (sts_q.size() <= base) begin
            errors++; resp = 2'bxx;
            $display("FAIL sts_timeout: %0d status words seen, required %0d", sts_q.size(), base + 1);
        end else resp = sts_q[base];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready,
             s_wr_ready, m_rd_valid, sts_valid} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0", {cmd_ready, m_axi_awvalid, m_axi_arvalid,
                     m_axi_wvalid, m_axi_bready, m_axi_rready, s_wr_ready, m_rd_valid, sts_valid});
        end
        checks++;
        if (sts_resp !== 2'b00) begin errors++; $display("FAIL reset_sts_resp: got %b, required 00", sts_resp); end
        checks++;
        if ({m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot} !==
            {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
            errors++; $display("FAIL aw_const: got %h %h %h %h %h %h, required 00 2 1 0 3 0", m_axi_awid,
                               m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot);
        end
        checks++;
        if ({m_axi_arid, m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot} !==
            {8'h00, 3'd2, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
            errors++; $display("FAIL ar_const: got %h %h %h %h %h %h, required 00 2 1 0 3 0", m_axi_arid,
                               m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_at_release: got %b, required 0", cmd_ready); end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_after_clk: got %b, required 1", cmd_ready); end
    endtask

    task automatic test_write();
        int aw0, w0, le0, we0, s0;
        logic [1:0] r;
        aw0 = aw_hs; w0 = w_beats; le0 = w_last_err; we0 = w_early; s0 = sts_q.size();
        bresp_cfg = 2'b00;
        issue_cmd(16'h0100, 8'd3, 1'b1);
        push_wr(4, 32'h11, 32'h11, 4'hF);
        wait_sts(s0, r);
        checks++;
        if (aw_hs - aw0 != 1) begin errors++; $display("FAIL wr_aw_count: got %0d, required 1", aw_hs - aw0); end
        checks++;
        if ({last_awaddr, last_awlen} !== {16'h0100, 8'd3}) begin
            errors++; $display("FAIL wr_aw_fields: got %h/%0d, required 0100/3", last_awaddr, last_awlen);
        end
        checks++;
        if (w_beats - w0 != 4) begin errors++; $display("FAIL wr_beats: got %0d, required 4", w_beats - w0); end
        checks++;
        if (w_last_err != le0 || w_early != we0) begin
            errors++; $display("FAIL wr_wlast_order: wlast errs %0d, early beats %0d, required 0/0",
                               w_last_err - le0, w_early - we0);
        end
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL wr_sts: got %b, required 00", r); end
        checks++;
        if (mem[10'h040] !== 32'h11 || mem[10'h043] !== 32'h44) begin
            errors++; $display("FAIL wr_mem: got %h %h, required 00000011 00000044", mem[10'h040], mem[10'h043]);
        end
    endtask

    task automatic test_read();
        int ar0, b0, s0, bad;
        logic [3:0] lasts;
        logic [1:0] r;
        ar0 = ar_hs; b0 = rd_q.size(); s0 = sts_q.size(); bad = 0; lasts = '0;
        issue_cmd(16'h0100, 8'd3, 1'b0);
        wait_sts(s0, r);
        checks++;
        if (ar_hs - ar0 != 1 || last_araddr !== 16'h0100 || last_arlen !== 8'd3) begin
            errors++; $display("FAIL rd_ar: count %0d addr %h len %0d, required 1/0100/3",
                               ar_hs - ar0, last_araddr, last_arlen);
        end
        checks++;
        if (rd_q.size() - b0 != 4) begin
            errors++; $display("FAIL rd_count: got %0d, required 4", rd_q.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rd_q[b0 + i] !== 32'h11 * (i + 1)) bad++;
                lasts[i] = rd_last_q[b0 + i];
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rd_data: %0d wrong beats, required 0", bad); end
            checks++;
            if (lasts !== 4'b1000) begin errors++; $display("FAIL rd_last: got %b, required 1000", lasts); end
        end
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL rd_sts: got %b, required 00", r); end
    endtask

    task automatic test_errors();
        int s0, w0, le0, b0;
        logic [1:0] r;
        // read with SLVERR on beat 2 of 4, OKAY afterwards
        s0 = sts_q.size(); b0 = rd_q.size();
        rerr_beat = 1; rerr_resp = 2'b10;
        issue_cmd(16'h0100, 8'd3, 1'b0);
        wait_sts(s0, r);
        rerr_beat = -1;
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL rd_err_sts: got %b, required 10", r); end
        checks++;
        if (rd_q.size() - b0 != 4) begin errors++; $display("FAIL rd_err_count: got %0d, required 4", rd_q.size() - b0); end
        // single-beat write, unaligned address, DECERR response
        s0 = sts_q.size(); w0 = w_beats; le0 = w_last_err;
        bresp_cfg = 2'b11;
        issue_cmd(16'h0203, 8'd0, 1'b1);
        push_wr(1, 32'hCAFE_F00D, 32'h0, 4'hF);
        wait_sts(s0, r);
        bresp_cfg = 2'b00;
        checks++;
        if (r !== 2'b11) begin errors++; $display("FAIL wr1_sts: got %b, required 11", r); end
        checks++;
        if ({last_awaddr, last_awlen} !== {16'h0200, 8'd0}) begin
            errors++; $display("FAIL wr1_aw: got %h/%0d, required 0200/0", last_awaddr, last_awlen);
        end
        checks++;
        if (w_beats - w0 != 1 || w_last_err != le0) begin
            errors++; $display("FAIL wr1_beat: beats %0d wlast errs %0d, required 1/0", w_beats - w0, w_last_err - le0);
        end
        // partial strobes over the word just written
        s0 = sts_q.size();
        issue_cmd(16'h0200, 8'd0, 1'b1);
        push_wr(1, 32'h1122_3344, 32'h0, 4'b0101);
        wait_sts(s0, r);
        checks++;
        if (mem[10'h080] !== 32'hCA22_F044 || r !== 2'b00) begin
            errors++; $display("FAIL wr_strb: mem %h sts %b, required ca22f044/00", mem[10'h080], r);
        end
    endtask

    task automatic test_backpressure();
        int aw0, w0, le0, st0, s0, b0, bad, nlast;
        logic [1:0] rw, rr;
        aw0 = aw_hs; w0 = w_beats; le0 = w_last_err; st0 = stab_err; bad = 0; nlast = 0;
        stall_en = 1'b1;
        s0 = sts_q.size();
        issue_cmd(16'h0400, 8'd255, 1'b1);
        push_wr(256, 32'hA500_0000, 32'h1, 4'hF);
        wait_sts(s0, rw);
        s0 = sts_q.size(); b0 = rd_q.size();
        issue_cmd(16'h0400, 8'd255, 1'b0);
        wait_sts(s0, rr);
        stall_en = 1'b0;
        checks++;
        if (aw_hs - aw0 != 1 || last_awlen !== 8'd255) begin
            errors++; $display("FAIL bp_aw: count %0d len %0d, required 1/255", aw_hs - aw0, last_awlen);
        end
        checks++;
        if (w_beats - w0 != 256 || w_last_err != le0) begin
            errors++; $display("FAIL bp_w: beats %0d wlast errs %0d, required 256/0", w_beats - w0, w_last_err - le0);
        end
        checks++;
        if (rd_q.size() - b0 != 256) begin
            errors++; $display("FAIL bp_rd_count: got %0d, required 256", rd_q.size() - b0);
        end else begin
            for (int i = 0; i < 256; i++) begin
                if (rd_q[b0 + i] !== 32'hA500_0000 + i) bad++;
                if (rd_last_q[b0 + i]) nlast = (i == 255) ? nlast + 1 : nlast + 100;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL bp_rd_data: %0d wrong beats, required 0", bad); end
            checks++;
            if (nlast != 1) begin errors++; $display("FAIL bp_rd_last: code %0d, required 1 (last on beat 256 only)", nlast); end
        end
        checks++;
        if (stab_err != st0) begin errors++; $display("FAIL bp_addr_stable: %0d changes, required 0", stab_err - st0); end
        checks++;
        if (rw !== 2'b00 || rr !== 2'b00) begin errors++; $display("FAIL bp_sts: got %b/%b, required 00/00", rw, rr); end
    endtask

    task automatic test_reset_mid_write();
        int w0, s0, b0, bad;
        logic [1:0] r;
        w0 = w_beats; s0 = sts_q.size(); bad = 0;
        issue_cmd(16'h0600, 8'd7, 1'b1);
        push_wr(2, 32'h5A5A_0000, 32'h1, 4'hF);
        checks++;
        if (w_beats - w0 != 2) begin errors++; $display("FAIL mid_beats: got %0d, required 2", w_beats - w0); end
        s_wr_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, m_axi_rready,
             s_wr_ready, m_rd_valid, sts_valid, sts_resp} !== 11'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b, required 0", {cmd_ready, m_axi_awvalid, m_axi_arvalid,
                     m_axi_wvalid, m_axi_bready, m_axi_rready, s_wr_ready, m_rd_valid, sts_valid, sts_resp});
        end
        @(negedge clk);
        rst = 1'b0; s_wr_valid = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_cmd_ready_release: got %b, required 0", cmd_ready); end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready_after: got %b, required 1", cmd_ready); end
        checks++;
        if (sts_q.size() != s0) begin errors++; $display("FAIL mid_no_status: got %0d words, required 0", sts_q.size() - s0); end
        b0 = rd_q.size();
        issue_cmd(16'h0100, 8'd3, 1'b0);
        wait_sts(s0, r);
        checks++;
        if (rd_q.size() - b0 != 4) begin
            errors++; $display("FAIL mid_rd_count: got %0d, required 4", rd_q.size() - b0);
        end else begin
            for (int i = 0; i < 4; i++) if (rd_q[b0 + i] !== 32'h11 * (i + 1)) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL mid_rd_data: %0d wrong beats, required 0", bad); end
        end
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL mid_rd_sts: got %b, required 00", r); end
    endtask

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    task automatic test_4k_check();
        int aw0, w0, s0;
        logic [1:0] r;
        aw0 = aw_hs; w0 = w_beats; s0 = sts_q.size();
        s_wr_valid = 1'b1; s_wr_data = 32'h0BAD_0BAD; s_wr_strb = 4'hF;
        issue_cmd(16'h0FF0, 8'd7, 1'b1);
        wait_sts(s0, r);
        s_wr_valid = 1'b0;
        checks++;
        if (r !== 2'b10) begin errors++; $display("FAIL k4_cross_sts: got %b, required 10", r); end
        checks++;
        if (aw_hs != aw0 || w_beats != w0) begin
            errors++; $display("FAIL k4_cross_quiet: aw %0d w %0d, required 0/0", aw_hs - aw0, w_beats - w0);
        end
        s0 = sts_q.size();
        issue_cmd(16'h0FE0, 8'd7, 1'b1);
        push_wr(8, 32'h7000_0000, 32'h1, 4'hF);
        wait_sts(s0, r);
        checks++;
        if (r !== 2'b00 || aw_hs - aw0 != 1 || last_awaddr !== 16'h0FE0) begin
            errors++; $display("FAIL k4_edge: sts %b aw %0d addr %h, required 00/1/0fe0", r, aw_hs - aw0, last_awaddr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_backpressure();
        test_reset_mid_write();
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
        test_4k_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 initiator (master) that turns single-command requests into one INCR burst on an AXI4 slave port, either read or write.
- Write data comes in on a valid/ready stream; read data goes out on a valid/ready stream; one status word is returned per command.
- Used to drive AXI4 memory slaves (e.g. on-chip RAM) from DMA-style control logic and from test harnesses.
- One transaction outstanding at a time; the read and write paths share a single state machine.

Parameters:
- DATA_WIDTH, 32, AXI data width in bits.
- ADDR_WIDTH, 16, AXI address width in bits.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width; must be a power of two.
- ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant driven on awid/arid.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_addr  in  ADDR_WIDTH  byte start address
- cmd_len  in  8  beats minus 1
- cmd_write  in  1  1 = write, 0 = read
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accept
- s_wr_data  in  DATA_WIDTH  write beat data
- s_wr_strb  in  STRB_WIDTH  write beat strobes
- s_wr_valid  in  1  write beat valid
- s_wr_ready  out  1  write beat accept
- m_rd_data  out  DATA_WIDTH  read beat data
- m_rd_last  out  1  final read beat
- m_rd_valid  out  1  read beat valid
- m_rd_ready  in  1  read beat accept
- sts_resp  out  2  worst-case AXI response of the command
- sts_valid  out  1  status valid
- sts_ready  in  1  status accept
- m_axi_aw*: id, addr, len, size, burst, lock, cache, prot, valid (out); ready (in). AXI4 write address channel.
- m_axi_w*: data, strb, last, valid (out); ready (in). AXI4 write data channel.
- m_axi_b*: id, resp, valid (in); ready (out). AXI4 write response channel.
- m_axi_ar*: same field set as aw* (out); ready (in). AXI4 read address channel.
- m_axi_r*: id, data, resp, last, valid (in); ready (out). AXI4 read data channel.

Behaviour:
- Constant address-channel fields:
  - awsize/arsize = $clog2(STRB_WIDTH).
  - burst = 2'b01 (INCR), lock = 0, cache = 4'b0011, prot = 3'b000.
  - addr = cmd_addr with the low $clog2(STRB_WIDTH) bits forced to 0.
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, STATUS.
- IDLE:
  - cmd_ready is registered: 0 in reset, 1 in IDLE from the first clk after rst deasserts.
  - On cmd_valid && cmd_ready: latch addr, len and write flag; clear the response accumulator.
  - Go to WR_ADDR if cmd_write, else RD_ADDR. cmd_ready falls the next cycle.
- WR_ADDR:
  - awvalid = 1, stays asserted until awready; address fields stay stable.
  - On the handshake, go to WR_DATA and load the beat counter with len.
- WR_DATA: W channel is combinational pass-through.
  - m_axi_wvalid = s_wr_valid, s_wr_ready = m_axi_wready, wdata/wstrb forwarded.
  - wlast = (counter == 0). The counter decrements on each W handshake.
  - Handshake with counter == 0 goes to WR_RESP.
  - No W beat is issued before the AW handshake.
- WR_RESP: bready = 1. On bvalid, accumulator := bresp; go to STATUS.
- RD_ADDR: arvalid held until arready, then go to RD_DATA.
- RD_DATA: R channel is pass-through.
  - m_rd_valid = rvalid, rready = m_rd_ready; m_rd_data = rdata, m_rd_last = rlast.
  - Each beat: accumulator := max(accumulator, rresp).
  - On a handshake with rlast = 1, go to STATUS. Beat count is not checked against len.
- STATUS:
  - sts_valid = 1 and sts_resp = accumulator, both held until sts_ready.
  - On the handshake, return to IDLE; cmd_ready rises the next cycle.
- bid/rid are ignored.
- Minimum latency: command accept to awvalid/arvalid is 1 cycle. Last B or R handshake to sts_valid is 1 cycle.
- Reset (any state, mid-burst included): state -> IDLE. awvalid, arvalid, bready, rready, s_wr_ready, m_rd_valid, sts_valid and cmd_ready all 0; sts_resp = 0. A partial burst is abandoned with no completion.
- Outside their states, wvalid, s_wr_ready, rready and m_rd_valid are forced to 0.
- len = 0 gives a single beat, with wlast asserted on the first beat.
- len = 255 gives 256 beats; the counter must not wrap early.
- Callers must not issue bursts that cross a 4 KB boundary, unless the optional check below is compiled in.

Optional Feature:
- Macro AXI_BURST_MASTER_4K_CHECK_EN.
- When defined: in IDLE, a command whose aligned start address plus (len+1)*STRB_WIDTH - 1 crosses a 4 KB boundary is accepted but not issued.
  - The block goes straight to STATUS with sts_resp = 2'b10 (SLVERR).
  - No AXI channel activity occurs and no s_wr beats are consumed.
- When undefined: no check is made and the burst is issued as commanded.

Test Plan:
- Write: addr 0x0100, len 3, data 0x11..0x44, strb 0xF, slave bresp 0 -> one AW (awlen 3, awaddr 0x0100), 4 W beats with wlast only on the 4th, sts_resp 0.
- Read back: addr 0x0100, len 3 -> m_rd_data 0x11,0x22,0x33,0x44, m_rd_last on the 4th, sts_resp 0.
- Backpressure: random wready/rready/m_rd_ready/sts_ready stalls on len 255 -> exactly 256 beats, no data loss, address/len stable while valid.
- Error: slave returns rresp 2'b10 on beat 2 of 4 -> sts_resp = 2'b10. Single-beat write (len 0) with bresp 2'b11 -> sts_resp 2'b11.
- Reset mid-write after 2 of 8 beats -> all valids and readies 0 immediately; cmd_ready 1 one cycle after release; a new read completes normally.
- With AXI_BURST_MASTER_4K_CHECK_EN: addr 0x0FF0, len 7, 32-bit bus -> sts_resp 2'b10 and no awvalid. addr 0x0FE0, len 7 -> issued normally.
